mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 41 ++++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared decode constants: ALU operation codes, HI/LO operation codes, and the
// state type of the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

    // ALU operation codes used by the E-stage ALU.
    localparam logic [3:0] ALU_add  = 4'd0;
    localparam logic [3:0] ALU_sub  = 4'd1;
    localparam logic [3:0] ALU_and  = 4'd2;
    localparam logic [3:0] ALU_or   = 4'd3;
    localparam logic [3:0] ALU_xor  = 4'd4;
    localparam logic [3:0] ALU_slt  = 4'd5;
    localparam logic [3:0] ALU_sltu = 4'd6;
    localparam logic [3:0] ALU_lui  = 4'd7;

    // HI/LO operation codes produced by the decode stage.
    localparam logic [3:0] HILO_none  = 4'd0;
    localparam logic [3:0] HILO_mult  = 4'd1;
    localparam logic [3:0] HILO_multu = 4'd2;
    localparam logic [3:0] HILO_div   = 4'd3;
    localparam logic [3:0] HILO_divu  = 4'd4;
    localparam logic [3:0] HILO_mthi  = 4'd5;
    localparam logic [3:0] HILO_mtlo  = 4'd6;
    localparam logic [3:0] HILO_mfhi  = 4'd7;
    localparam logic [3:0] HILO_mflo  = 4'd8;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_start_op(input logic [3:0] t);
        return (t == HILO_mult) || (t == HILO_multu) ||
               (t == HILO_div)  || (t == HILO_divu);
    endfunction

    function automatic logic is_div_op(input logic [3:0] t);
        return (t == HILO_div) || (t == HILO_divu);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage to HI/LO unit connection.
//
// Handshake: start is a request that the unit accepts on the next rising edge
// only while busy=0. There is no back-pressure wire: the pipeline must hold
// any HI/LO instruction in D while start or busy is set, and the unit drops
// any request that arrives while busy=1.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        en;
    logic [3:0]  hilo_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hilo_out;
    md_state_t   state_dbg;

    modport master (
        output en, hilo_type, rs_val, rt_val,
        input  start, busy, hilo_out, state_dbg
    );

    modport slave (
        input  en, hilo_type, rs_val, rt_val,
        output start, busy, hilo_out, state_dbg
    );

endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. The 64-bit result is computed when the request
// is accepted and parked in temp registers; HI/LO are only updated when the
// busy window closes, so the pipeline sees the documented multi-cycle latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    md_state_t          state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_load;
    logic [31:0]        hi, lo, temp_hi, temp_lo;
    logic               skip_write;
    logic               accept, finish;
    logic               rt_zero;
    logic [63:0]        result;
    logic signed [63:0] s_rs, s_rt, s_dvs;
    logic [63:0]        u_rs, u_rt, u_dvs;

    // A zero divisor is swapped for 1 so the divider never sees 0; the result
    // is thrown away at completion anyway.
    assign rt_zero = (bus.rt_val == 32'd0);
    assign s_rs    = {{32{bus.rs_val[31]}}, bus.rs_val};
    assign s_rt    = {{32{bus.rt_val[31]}}, bus.rt_val};
    assign s_dvs   = rt_zero ? 64'sd1 : s_rt;
    assign u_rs    = {32'd0, bus.rs_val};
    assign u_rt    = {32'd0, bus.rt_val};
    assign u_dvs   = rt_zero ? 64'd1 : u_rt;

    assign bus.start     = bus.en && is_start_op(bus.hilo_type);
    assign bus.busy      = (state == MD_BUSY);
    assign bus.state_dbg = state;
    assign cnt_load      = is_div_op(bus.hilo_type) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Full 64-bit result of the requested operation, {HI, LO}.
    always_comb begin
        result = '0;
        case (bus.hilo_type)
            HILO_mult:  result = s_rs * s_rt;
            HILO_multu: result = u_rs * u_rt;
            HILO_div:   result = {32'(s_rs % s_dvs), 32'(s_rs / s_dvs)};
            HILO_divu:  result = {32'(u_rs % u_dvs), 32'(u_rs / u_dvs)};
            default:    result = '0;
        endcase
    end

    // Next state: accept only from idle, leave busy when the count reaches 1.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_next;
    end

    // Datapath: operand capture, countdown, HI/LO commit and mthi/mtlo writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            temp_hi    <= '0;
            temp_lo    <= '0;
            skip_write <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else if (accept) begin
            cnt        <= cnt_load;
            temp_hi    <= result[63:32];
            temp_lo    <= result[31:0];
            skip_write <= is_div_op(bus.hilo_type) && rt_zero;
        end else if (state == MD_BUSY) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            if (finish && !skip_write) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end
        end else if (bus.en) begin
            if (bus.hilo_type == HILO_mthi) hi <= bus.rs_val;
            if (bus.hilo_type == HILO_mtlo) lo <= bus.rs_val;
        end
    end

    // Read port for mfhi/mflo.
    always_comb begin
        bus.hilo_out = '0;
        if (bus.hilo_type == HILO_mfhi)      bus.hilo_out = hi;
        else if (bus.hilo_type == HILO_mflo) bus.hilo_out = lo;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of arithmetic vectors plus
// hand-written sequences for zero divisors, mid-operation reset and requests
// arriving while busy.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mult_div_unit_if bus_if();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] op,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus_if.en        = en;
        bus_if.hilo_type = op;
        bus_if.rs_val    = rs;
        bus_if.rt_val    = rt;
    endtask

    task automatic drive_idle();
        drive(1'b0, HILO_none, 32'd0, 32'd0);
    endtask

    // Present a multi-cycle op from idle and let the accept edge pass.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [31:0] rs, input logic [31:0] rt);
        drive(1'b1, op, rs, rt);
        #1;
        check({name, " start"}, 32'(bus_if.start), 32'd1);
        check({name, " idle before"}, 32'(bus_if.busy), 32'd0);
        tick();
        drive_idle();
    endtask

    // Count busy cycles, starting with the current one.
    task automatic wait_done(output int n);
        n = 0;
        while (bus_if.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        drive(1'b1, HILO_mfhi, 32'd0, 32'd0);
        #1;
        check({name, " HI"}, bus_if.hilo_out, hi);
        drive(1'b1, HILO_mflo, 32'd0, 32'd0);
        #1;
        check({name, " LO"}, bus_if.hilo_out, lo);
        drive_idle();
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
        drive(1'b1, op, val, 32'd0);
        tick();
        drive_idle();
    endtask

    initial begin
        int n;
        int m;

        vecs[0] = '{HILO_mult,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{HILO_multu, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{HILO_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{HILO_divu,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[4] = '{HILO_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{HILO_mult,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[6] = '{HILO_multu, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[7] = '{HILO_div,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8] = '{HILO_divu,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

        // Reset state.
        rst_n = 1'b0;
        drive_idle();
        repeat (2) tick();
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset state", 32'(bus_if.state_dbg), 32'(MD_IDLE));
        check_hilo("reset", 32'd0, 32'd0);
        check("none out", bus_if.hilo_out, 32'd0);
        drive(1'b0, HILO_mult, 32'd1, 32'd1);
        #1;
        check("en0 start", 32'(bus_if.start), 32'd0);
        drive_idle();
        rst_n = 1'b1;
        tick();

        // en=0 must not write HI or start anything.
        drive(1'b0, HILO_mthi, 32'h0000FFFF, 32'd0);
        tick();
        drive(1'b0, HILO_div, 32'd9, 32'd3);
        tick();
        check("en0 busy", 32'(bus_if.busy), 32'd0);
        check_hilo("en0", 32'd0, 32'd0);

        // Table of arithmetic vectors.
        for (int i = 0; i < 9; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(n);
            check($sformatf("vec%0d cycles", i), 32'(n), 32'(vecs[i].cyc));
            check_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // mthi/mtlo, then divide by zero leaves HI/LO alone.
        write_hilo(HILO_mthi, 32'h00001234);
        write_hilo(HILO_mtlo, 32'h00005678);
        check("mt busy", 32'(bus_if.busy), 32'd0);
        check_hilo("mt", 32'h00001234, 32'h00005678);
        issue("divu0", HILO_divu, 32'd5, 32'd0);
        wait_done(n);
        check("divu0 cycles", 32'(n), 32'd10);
        check_hilo("divu0", 32'h00001234, 32'h00005678);

        // Requests arriving while a mult is in flight are dropped.
        issue("mult busy", HILO_mult, 32'd6, 32'd7);
        tick();
        check("busy cyc2", 32'(bus_if.busy), 32'd1);
        drive(1'b1, HILO_div, 32'd100, 32'd3);
        #1;
        check("busy req start", 32'(bus_if.start), 32'd1);
        tick();
        drive(1'b1, HILO_mthi, 32'h0000DEAD, 32'd0);
        tick();
        drive_idle();
        wait_done(m);
        check("busy mult cycles", 32'(3 + m), 32'd5);
        check_hilo("busy mult", 32'd0, 32'd42);
        tick();
        check("no queued div", 32'(bus_if.busy), 32'd0);

        // Reset in busy cycle 4 of a divide.
        issue("div rst", HILO_div, 32'd100, 32'd7);
        repeat (3) tick();
        check("div rst cyc4", 32'(bus_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(bus_if.busy), 32'd0);
        check_hilo("rst now", 32'd0, 32'd0);
        rst_n = 1'b1;
        repeat (12) tick();
        check("rst late busy", 32'(bus_if.busy), 32'd0);
        check_hilo("rst late", 32'd0, 32'd0);

        // First request after reset is a normal accept.
        issue("post rst", HILO_mult, 32'd3, 32'd4);
        wait_done(n);
        check("post rst cycles", 32'(n), 32'd5);
        check_hilo("post rst", 32'd0, 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
